// File: rtl/sa_wresp_channel_pkg.sv
// Shared widths and helpers for the slave-side write-response router.
// Defaults describe the standard two-master, eight-outstanding configuration.
package sa_wresp_channel_pkg;

    localparam int unsigned DEF_MST_AMT         = 2;
    localparam int unsigned DEF_OUTSTANDING_AMT = 8;
    localparam int unsigned DEF_TRANS_MST_ID_W  = 5;
    localparam int unsigned DEF_TRANS_WR_RESP_W = 2;

    // Index width that never collapses to zero bits for a single master.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned resp_info_width(input int unsigned id_w,
                                                    input int unsigned resp_w);
        return id_w + resp_w;
    endfunction

    localparam int unsigned DEF_MST_ID_W    = idx_width(DEF_MST_AMT);
    localparam int unsigned DEF_RESP_INFO_W = resp_info_width(DEF_TRANS_MST_ID_W,
                                                              DEF_TRANS_WR_RESP_W);

endpackage

// File: rtl/sa_wresp_channel_fifo.sv
// Synchronous FIFO with registered full/empty flags and no write-to-read bypass.
// A pop in the same cycle frees a slot for a push even when full.
module sa_wresp_channel_fifo #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned FIFO_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PTR_W = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_WIDTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_WIDTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_WIDTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_WIDTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop  = rd_en_i & ~empty_q;
    assign push = wr_en_i & (~full_q | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(FIFO_WIDTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FIFO_WIDTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/sa_wresp_channel.sv
// Steers slave B responses to the owning master's dispatcher, using AW-grant
// order recorded in a FIFO, through a single registered output stage.
module sa_wresp_channel
    import sa_wresp_channel_pkg::*;
#(
    parameter int unsigned MST_AMT         = DEF_MST_AMT,
    parameter int unsigned OUTSTANDING_AMT = DEF_OUTSTANDING_AMT,
    parameter int unsigned TRANS_MST_ID_W  = DEF_TRANS_MST_ID_W,
    parameter int unsigned TRANS_WR_RESP_W = DEF_TRANS_WR_RESP_W,
    parameter int unsigned MST_ID_W        = idx_width(MST_AMT)
) (
    input  logic                                 ACLK_i,
    input  logic                                 ARESETn_i,
    input  logic [MST_ID_W-1:0]                  sa_AW_mst_id_i,
    input  logic                                 sa_AW_shift_en_i,
    output logic                                 sa_AW_ord_full_o,
    input  logic [TRANS_MST_ID_W-1:0]            s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]           s_BRESP_i,
    input  logic                                 s_BVALID_i,
    output logic                                 s_BREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]   dsp_BRESP_o,
    output logic [MST_AMT-1:0]                   dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                   dsp_BREADY_i
);

    localparam int unsigned RESP_INFO_W = resp_info_width(TRANS_MST_ID_W, TRANS_WR_RESP_W);

    logic                   ord_full;
    logic                   ord_empty;
    logic [MST_ID_W-1:0]    head_idx;

    logic                   out_valid_q, out_valid_d;
    logic [MST_ID_W-1:0]    out_idx_q, out_idx_d;
    logic [RESP_INFO_W-1:0] out_info_q, out_info_d;

    logic                   out_accept;
    logic                   out_free;
    logic                   b_hs;

    sa_wresp_channel_fifo #(
        .DATA_WIDTH (MST_ID_W),
        .FIFO_WIDTH (OUTSTANDING_AMT)
    ) u_ord_fifo (
        .clk_i     (ACLK_i),
        .rst_ni    (ARESETn_i),
        .wr_en_i   (sa_AW_shift_en_i),
        .wr_data_i (sa_AW_mst_id_i),
        .rd_en_i   (b_hs),
        .rd_data_o (head_idx),
        .full_o    (ord_full),
        .empty_o   (ord_empty)
    );

    // Refill in the same cycle the current response drains keeps 1 resp/cycle.
    assign out_accept = out_valid_q & dsp_BREADY_i[out_idx_q];
    assign out_free   = ~out_valid_q | out_accept;
    assign s_BREADY_o = ~ord_empty & out_free;
    assign b_hs       = s_BVALID_i & s_BREADY_o;

    assign sa_AW_ord_full_o = ord_full;

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_info_d  = out_info_q;
        if (b_hs) begin
            out_valid_d = 1'b1;
            out_idx_d   = head_idx;
            out_info_d  = {s_BID_i, s_BRESP_i};
        end else if (out_accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_info_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_info_q  <= out_info_d;
        end
    end

    // Only the owning master's slice carries the payload; the rest read zero.
    always_comb begin
        dsp_BVALID_o = '0;
        dsp_BID_o    = '0;
        dsp_BRESP_o  = '0;
        for (int unsigned i = 0; i < MST_AMT; i++) begin
            if (out_valid_q && (out_idx_q == MST_ID_W'(i))) begin
                dsp_BVALID_o[i] = 1'b1;
                dsp_BID_o[i*TRANS_MST_ID_W +: TRANS_MST_ID_W] =
                    out_info_q[RESP_INFO_W-1 -: TRANS_MST_ID_W];
                dsp_BRESP_o[i*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] =
                    out_info_q[TRANS_WR_RESP_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sa_wresp_channel.sv
// Directed vector bench for sa_wresp_channel with two masters and a four-deep order FIFO.
module tb_sa_wresp_channel;

    localparam int unsigned MST_AMT = 2;
    localparam int unsigned OUT_AMT = 4;
    localparam int unsigned ID_W    = 5;
    localparam int unsigned RESP_W  = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      aw_id;
    logic                      aw_en;
    logic                      ord_full;
    logic [ID_W-1:0]           bid;
    logic [RESP_W-1:0]         bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ID_W*MST_AMT-1:0]   dsp_bid;
    logic [RESP_W*MST_AMT-1:0] dsp_bresp;
    logic [MST_AMT-1:0]        dsp_bvalid;
    logic [MST_AMT-1:0]        dsp_bready;

    int checks = 0;
    int errors = 0;

    sa_wresp_channel #(
        .MST_AMT         (MST_AMT),
        .OUTSTANDING_AMT (OUT_AMT),
        .TRANS_MST_ID_W  (ID_W),
        .TRANS_WR_RESP_W (RESP_W),
        .MST_ID_W        (1)
    ) dut (
        .ACLK_i           (clk),
        .ARESETn_i        (rst_n),
        .sa_AW_mst_id_i   (aw_id),
        .sa_AW_shift_en_i (aw_en),
        .sa_AW_ord_full_o (ord_full),
        .s_BID_i          (bid),
        .s_BRESP_i        (bresp),
        .s_BVALID_i       (bvalid),
        .s_BREADY_o       (bready),
        .dsp_BID_o        (dsp_bid),
        .dsp_BRESP_o      (dsp_bresp),
        .dsp_BVALID_o     (dsp_bvalid),
        .dsp_BREADY_i     (dsp_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       aw_en;
        logic       aw_id;
        logic       bvalid;
        logic [4:0] bid;
        logic [1:0] bresp;
        logic [1:0] bready;
        logic       e_sready;
        logic       e_full;
        logic [1:0] e_bvalid;
        logic [9:0] e_bid;
        logic [3:0] e_bresp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic a_en, input logic a_id, input logic bv,
                                input logic [4:0] b_id, input logic [1:0] b_rs,
                                input logic [1:0] rdy, input logic e_sr, input logic e_fl,
                                input logic [1:0] e_bv, input logic [9:0] e_id,
                                input logic [3:0] e_rs);
        vec_t v;
        v.aw_en = a_en; v.aw_id = a_id; v.bvalid = bv; v.bid = b_id; v.bresp = b_rs;
        v.bready = rdy; v.e_sready = e_sr; v.e_full = e_fl; v.e_bvalid = e_bv;
        v.e_bid = e_id; v.e_bresp = e_rs;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a_en, input logic a_id, input logic bv,
                         input logic [4:0] b_id, input logic [1:0] b_rs, input logic [1:0] rdy);
        aw_en = a_en; aw_id = a_id; bvalid = bv; bid = b_id; bresp = b_rs; dsp_bready = rdy;
    endtask

    initial begin
        // single response to master 1
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 5,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 2, 10'h0A0, 4'h0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        // back-to-back routing 0,1,0
        vecs.push_back(mk(1, 0, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 1,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 2,  2, 3, 1, 0, 1, 10'h001, 4'h0));
        vecs.push_back(mk(0, 0, 1, 3,  3, 3, 1, 0, 2, 10'h040, 4'h8));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 1, 10'h003, 4'h3));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        // dispatcher 0 back-pressure, push+pop at occupancy 1
        vecs.push_back(mk(1, 0, 0, 0,  0, 2, 0, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 0, 1, 7,  1, 2, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 8,  0, 2, 0, 0, 1, 10'h007, 4'h1));
        vecs.push_back(mk(0, 0, 1, 8,  0, 2, 0, 0, 1, 10'h007, 4'h1));
        vecs.push_back(mk(0, 0, 1, 8,  0, 2, 0, 0, 1, 10'h007, 4'h1));
        vecs.push_back(mk(0, 0, 1, 8,  0, 3, 1, 0, 1, 10'h007, 4'h1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 1, 10'h008, 4'h0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        // fill to full, ignored fifth push, pop from full, push+pop at 3
        vecs.push_back(mk(1, 1, 0, 0,  0, 3, 0, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 3, 1, 1, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 9,  2, 3, 1, 1, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 1, 0, 2, 10'h120, 4'h8));
        vecs.push_back(mk(1, 0, 1, 10, 0, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 11, 1, 3, 1, 0, 2, 10'h140, 4'h0));
        vecs.push_back(mk(0, 0, 1, 12, 0, 3, 1, 0, 1, 10'h00B, 4'h1));
        vecs.push_back(mk(0, 0, 1, 13, 3, 3, 1, 0, 2, 10'h180, 4'h0));
        // stray response with empty FIFO, then late push
        vecs.push_back(mk(0, 0, 1, 14, 0, 3, 0, 0, 1, 10'h00D, 4'h3));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 0, 1, 14, 0, 3, 0, 0, 0, 10'h000, 4'h0));
        end
        vecs.push_back(mk(1, 1, 1, 14, 0, 3, 0, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 1, 14, 1, 3, 1, 0, 0, 10'h000, 4'h0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0, 0, 2, 10'h1C0, 4'h4));

        // reset state, with a stray BVALID present
        rst_n = 1'b0;
        drive(0, 0, 1, 5'd3, 2'd1, 2'b11);
        #12;
        chk("rst sready", 32'(bready), 32'd0);
        chk("rst full", 32'(ord_full), 32'd0);
        chk("rst bvalid", 32'(dsp_bvalid), 32'd0);
        chk("rst bid", 32'(dsp_bid), 32'd0);
        chk("rst bresp", 32'(dsp_bresp), 32'd0);
        #10 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].aw_en, vecs[i].aw_id, vecs[i].bvalid, vecs[i].bid,
                     vecs[i].bresp, vecs[i].bready);
            #3;
            chk($sformatf("v%0d sready", i), 32'(bready), 32'(vecs[i].e_sready));
            chk($sformatf("v%0d full", i), 32'(ord_full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d bvalid", i), 32'(dsp_bvalid), 32'(vecs[i].e_bvalid));
            chk($sformatf("v%0d bid", i), 32'(dsp_bid), 32'(vecs[i].e_bid));
            chk($sformatf("v%0d bresp", i), 32'(dsp_bresp), 32'(vecs[i].e_bresp));
        end

        // asynchronous reset while master 0 holds a response and one entry is pending
        @(posedge clk); #1 drive(1, 0, 0, 5'd0, 2'd0, 2'b11);
        @(posedge clk); #1 drive(1, 0, 1, 5'd3, 2'd1, 2'b11);
        #3 chk("pre-rst sready", 32'(bready), 32'd1);
        @(posedge clk); #1 drive(0, 0, 0, 5'd0, 2'd0, 2'b00);
        #3;
        chk("pre-rst bvalid", 32'(dsp_bvalid), 32'd1);
        chk("pre-rst bid", 32'(dsp_bid), 32'h003);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst bvalid", 32'(dsp_bvalid), 32'd0);
        chk("mid-rst bid", 32'(dsp_bid), 32'd0);
        chk("mid-rst bresp", 32'(dsp_bresp), 32'd0);
        chk("mid-rst full", 32'(ord_full), 32'd0);
        chk("mid-rst sready", 32'(bready), 32'd0);
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1 drive(0, 0, 1, 5'd4, 2'd0, 2'b11);
        #3;
        chk("post-rst sready", 32'(bready), 32'd0);
        chk("post-rst bvalid", 32'(dsp_bvalid), 32'd0);
        @(posedge clk); #4;
        chk("post-rst sready2", 32'(bready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
